// File: rtl/alu_pkg.sv
// Shared ALU operation encodings, MIPS opcode/funct constants and the
// decode result record used by the issue controller and its decoder.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_MUL  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_AND  = 4'b0100,
        ALU_XOR  = 4'b0101,
        ALU_NAND = 4'b0110,
        ALU_SLT  = 4'b0111,
        ALU_SLTU = 4'b1000,
        ALU_SLL  = 4'b1001,
        ALU_SRL  = 4'b1010,
        ALU_SRA  = 4'b1011
    } alu_op_e;

    localparam logic [5:0] OPC_RTYPE    = 6'b000000;
    localparam logic [5:0] OPC_BEQ      = 6'b000100;
    localparam logic [5:0] OPC_BNE      = 6'b000101;
    localparam logic [5:0] OPC_ADDI     = 6'b001000;
    localparam logic [5:0] OPC_ADDIU    = 6'b001001;
    localparam logic [5:0] OPC_SLTI     = 6'b001010;
    localparam logic [5:0] OPC_SLTIU    = 6'b001011;
    localparam logic [5:0] OPC_ANDI     = 6'b001100;
    localparam logic [5:0] OPC_ORI      = 6'b001101;
    localparam logic [5:0] OPC_XORI     = 6'b001110;
    localparam logic [5:0] OPC_SPECIAL2 = 6'b011100;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_MUL  = 6'b000010;  // under OPC_SPECIAL2

    typedef struct packed {
        alu_op_e     op;
        logic [31:0] a;
        logic [31:0] b;
        logic        illegal;
    } dec_t;

    // Unsupported encodings drive a zeroed add so the ALU sees quiet inputs.
    localparam dec_t ILLEGAL_DEC = '{op: ALU_ADD, a: 32'd0, b: 32'd0, illegal: 1'b1};

    function automatic dec_t mk_dec(alu_op_e op, logic [31:0] a, logic [31:0] b);
        dec_t d;
        d.op      = op;
        d.a       = a;
        d.b       = b;
        d.illegal = 1'b0;
        return d;
    endfunction

endpackage

// File: rtl/alu_issue_ctrl_if.sv
// Instruction, ALU and result channels of the ALU issue controller.
// master = environment (instruction source, ALU, result sink); slave = controller.
interface alu_issue_ctrl_if;
    logic        in_valid;
    logic        in_ready;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [4:0]  shamt;
    logic [15:0] imm;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [31:0] alu_r;
    logic        alu_z;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_illegal;

    modport master (
        output in_valid, opcode, funct, shamt, imm, rs_val, rt_val, alu_r, alu_z, out_ready,
        input  in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_zero, out_illegal
    );

    modport slave (
        input  in_valid, opcode, funct, shamt, imm, rs_val, rt_val, alu_r, alu_z, out_ready,
        output in_ready, alu_a, alu_b, alu_op, out_valid, out_result, out_zero, out_illegal
    );
endinterface

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode to ALU operation and operands.
// Optional feature: ALU_ISSUE_MUL_EN enables SPECIAL2 mul; otherwise it is illegal.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic [4:0]  shamt,
    input  logic [15:0] imm,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output dec_t        dec
);

    logic [31:0] imm_s;
    logic [31:0] imm_z;
    logic [31:0] sh_imm;
    logic [31:0] sh_var;

    assign imm_s  = {{16{imm[15]}}, imm};
    assign imm_z  = {16'd0, imm};
    assign sh_imm = {27'd0, shamt};
    assign sh_var = {27'd0, rs_val[4:0]};

    // Anything not matched below stays at the illegal default.
    always_comb begin
        dec = ILLEGAL_DEC;
        case (opcode)
            OPC_RTYPE: begin
                case (funct)
                    FN_ADD, FN_ADDU: dec = mk_dec(ALU_ADD,  rs_val, rt_val);
                    FN_SUB, FN_SUBU: dec = mk_dec(ALU_SUB,  rs_val, rt_val);
                    FN_AND:          dec = mk_dec(ALU_AND,  rs_val, rt_val);
                    FN_OR:           dec = mk_dec(ALU_OR,   rs_val, rt_val);
                    FN_XOR:          dec = mk_dec(ALU_XOR,  rs_val, rt_val);
                    FN_SLT:          dec = mk_dec(ALU_SLT,  rs_val, rt_val);
                    FN_SLTU:         dec = mk_dec(ALU_SLTU, rs_val, rt_val);
                    FN_SLL:          dec = mk_dec(ALU_SLL,  rt_val, sh_imm);
                    FN_SRL:          dec = mk_dec(ALU_SRL,  rt_val, sh_imm);
                    FN_SRA:          dec = mk_dec(ALU_SRA,  rt_val, sh_imm);
                    FN_SLLV:         dec = mk_dec(ALU_SLL,  rt_val, sh_var);
                    FN_SRLV:         dec = mk_dec(ALU_SRL,  rt_val, sh_var);
                    FN_SRAV:         dec = mk_dec(ALU_SRA,  rt_val, sh_var);
                    default:         dec = ILLEGAL_DEC;
                endcase
            end
            OPC_ADDI, OPC_ADDIU: dec = mk_dec(ALU_ADD,  rs_val, imm_s);
            OPC_SLTI:            dec = mk_dec(ALU_SLT,  rs_val, imm_s);
            OPC_SLTIU:           dec = mk_dec(ALU_SLTU, rs_val, imm_s);
            OPC_ANDI:            dec = mk_dec(ALU_AND,  rs_val, imm_z);
            OPC_ORI:             dec = mk_dec(ALU_OR,   rs_val, imm_z);
            OPC_XORI:            dec = mk_dec(ALU_XOR,  rs_val, imm_z);
            // Branch compare: the ALU zero flag is the equality result.
            OPC_BEQ, OPC_BNE:    dec = mk_dec(ALU_SUB,  rs_val, rt_val);
`ifdef ALU_ISSUE_MUL_EN
            OPC_SPECIAL2: begin
                if (funct == FN_MUL) dec = mk_dec(ALU_MUL, rs_val, rt_val);
            end
`endif
            default:             dec = ILLEGAL_DEC;
        endcase
    end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Two-stage issue pipeline around an external combinational ALU.
// Stage 1 holds the decoded ALU op/operands, stage 2 captures the ALU result.
// Optional feature: ALU_ISSUE_MUL_EN (handled in alu_issue_decode).
module alu_issue_ctrl
    import alu_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    alu_issue_ctrl_if.slave  bus
);

    dec_t        dec;
    logic        s1_valid;
    logic        s1_illegal;
    logic [3:0]  s1_op;
    logic [31:0] s1_a;
    logic [31:0] s1_b;
    logic        o_valid;
    logic [31:0] o_result;
    logic        o_zero;
    logic        o_illegal;
    logic        adv;
    logic        ready;
    logic        take;

    alu_issue_decode u_decode (
        .opcode (bus.opcode),
        .funct  (bus.funct),
        .shamt  (bus.shamt),
        .imm    (bus.imm),
        .rs_val (bus.rs_val),
        .rt_val (bus.rt_val),
        .dec    (dec)
    );

    // Stage 2 can take a new entry when empty or being drained this edge;
    // stage 1 can then take one when it is empty or moving into stage 2.
    assign adv   = !o_valid || bus.out_ready;
    assign ready = !s1_valid || adv;
    assign take  = bus.in_valid && ready;

    assign bus.in_ready    = ready;
    assign bus.alu_op      = s1_op;
    assign bus.alu_a       = s1_a;
    assign bus.alu_b       = s1_b;
    assign bus.out_valid   = o_valid;
    assign bus.out_result  = o_result;
    assign bus.out_zero    = o_zero;
    assign bus.out_illegal = o_illegal;

    // Stage 1: operands only change on acceptance, so they hold while stalled or idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid   <= 1'b0;
            s1_illegal <= 1'b0;
            s1_op      <= 4'd0;
            s1_a       <= 32'd0;
            s1_b       <= 32'd0;
        end else begin
            if (ready) s1_valid <= bus.in_valid;
            if (take) begin
                s1_op      <= dec.op;
                s1_a       <= dec.a;
                s1_b       <= dec.b;
                s1_illegal <= dec.illegal;
            end
        end
    end

    // Stage 2: capture the ALU result; illegal entries report zero result and flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            o_valid   <= 1'b0;
            o_result  <= 32'd0;
            o_zero    <= 1'b0;
            o_illegal <= 1'b0;
        end else if (adv) begin
            o_valid <= s1_valid;
            if (s1_valid) begin
                o_result  <= s1_illegal ? 32'd0 : bus.alu_r;
                o_zero    <= s1_illegal ? 1'b0  : bus.alu_z;
                o_illegal <= s1_illegal;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: directed cases, back-to-back/stall traffic and
// randomized traffic scored against an instruction-level result model.
module tb_alu_issue_ctrl;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic        ill;
        int          age;   // edges seen, counting the accept edge
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   n_out  = 0;
    exp_t q[$];
    bit          hold_v = 1'b0;
    logic [31:0] hold_res;
    logic        hold_zero;
    logic        hold_ill;
    logic [3:0]  rdy_pat = 4'b1001;   // out_ready sequence 1,0,0,1

    logic [5:0] opc_tab [0:26] = '{6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00,
                                   6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0a,
                                   6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h04, 6'h05, 6'h1c, 6'h00, 6'h3f};
    logic [5:0] fn_tab  [0:26] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h2a, 6'h2b,
                                   6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h00, 6'h00, 6'h00,
                                   6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h02, 6'h27, 6'h00};

    always #5 clk = ~clk;

    alu_issue_ctrl_if bus();

    alu_issue_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Combinational ALU seen by the controller.
    always_comb begin
        logic [31:0] r;
        r = 32'd0;
        case (bus.alu_op)
            4'd0:  r = bus.alu_a + bus.alu_b;
            4'd1:  r = bus.alu_a - bus.alu_b;
            4'd2:  r = bus.alu_a * bus.alu_b;
            4'd3:  r = bus.alu_a | bus.alu_b;
            4'd4:  r = bus.alu_a & bus.alu_b;
            4'd5:  r = bus.alu_a ^ bus.alu_b;
            4'd6:  r = ~(bus.alu_a & bus.alu_b);
            4'd7:  r = {31'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            4'd8:  r = {31'd0, bus.alu_a < bus.alu_b};
            4'd9:  r = bus.alu_a << bus.alu_b[4:0];
            4'd10: r = bus.alu_a >> bus.alu_b[4:0];
            4'd11: r = $signed(bus.alu_a) >>> bus.alu_b[4:0];
            default: r = 32'd0;
        endcase
        bus.alu_r = r;
        bus.alu_z = (r == 32'd0);
    end

    // What each instruction means, straight from the MIPS semantics.
    function automatic exp_t ref_model(logic [5:0] opc, logic [5:0] fn, logic [4:0] sh,
                                       logic [15:0] im, logic [31:0] rs, logic [31:0] rt);
        exp_t e;
        logic [31:0] si;
        logic [31:0] zi;
        si = {{16{im[15]}}, im};
        zi = {16'd0, im};
        e.res = 32'd0;
        e.ill = 1'b0;
        e.age = 0;
        case (opc)
            6'h00: case (fn)
                6'h20, 6'h21: e.res = rs + rt;
                6'h22, 6'h23: e.res = rs - rt;
                6'h24: e.res = rs & rt;
                6'h25: e.res = rs | rt;
                6'h26: e.res = rs ^ rt;
                6'h2a: e.res = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                6'h2b: e.res = (rs < rt) ? 32'd1 : 32'd0;
                6'h00: e.res = rt << sh;
                6'h02: e.res = rt >> sh;
                6'h03: e.res = $signed(rt) >>> sh;
                6'h04: e.res = rt << rs[4:0];
                6'h06: e.res = rt >> rs[4:0];
                6'h07: e.res = $signed(rt) >>> rs[4:0];
                default: e.ill = 1'b1;
            endcase
            6'h08, 6'h09: e.res = rs + si;
            6'h0a: e.res = ($signed(rs) < $signed(si)) ? 32'd1 : 32'd0;
            6'h0b: e.res = (rs < si) ? 32'd1 : 32'd0;
            6'h0c: e.res = rs & zi;
            6'h0d: e.res = rs | zi;
            6'h0e: e.res = rs ^ zi;
            6'h04, 6'h05: e.res = rs - rt;
            6'h1c: begin
                if (fn == 6'h02) begin
`ifdef ALU_ISSUE_MUL_EN
                    e.res = rs * rt;
`else
                    e.ill = 1'b1;
`endif
                end else begin
                    e.ill = 1'b1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        e.zero = !e.ill && (e.res == 32'd0);
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: observe at the falling edge, then let the rising edge happen.
    task automatic tick(output bit acc);
        acc = 1'b0;
        @(negedge clk);
        if (rst) begin
            q.delete();
            hold_v = 1'b0;
        end else begin
            chk("in_ready", 32'((q.size() < 2) || bus.out_ready), 32'(bus.in_ready));
            if (q.size() > 0) chk("out_valid", 32'(bus.out_valid), 32'(q[0].age >= 2));
            else              chk("out_valid_idle", 32'(bus.out_valid), 32'd0);
            if (hold_v) begin
                chk("hold_result", bus.out_result, hold_res);
                chk("hold_zero", 32'(bus.out_zero), 32'(hold_zero));
                chk("hold_illegal", 32'(bus.out_illegal), 32'(hold_ill));
            end
            if (bus.out_valid && q.size() > 0) begin
                chk("sb_result", bus.out_result, q[0].res);
                chk("sb_zero", 32'(bus.out_zero), 32'(q[0].zero));
                chk("sb_illegal", 32'(bus.out_illegal), 32'(q[0].ill));
            end
`ifndef ALU_ISSUE_MUL_EN
            chk("no_mul_op", 32'(bus.alu_op == 4'd2), 32'd0);
`endif
            hold_v    = bus.out_valid && !bus.out_ready;
            hold_res  = bus.out_result;
            hold_zero = bus.out_zero;
            hold_ill  = bus.out_illegal;
            if (bus.out_valid && bus.out_ready && q.size() > 0) begin
                void'(q.pop_front());
                n_out++;
            end
            if (bus.in_valid && bus.in_ready) begin
                q.push_back(ref_model(bus.opcode, bus.funct, bus.shamt, bus.imm,
                                      bus.rs_val, bus.rt_val));
                acc = 1'b1;
            end
            foreach (q[i]) q[i].age++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_rand();
        int idx;
        idx = $urandom_range(0, 26);
        bus.opcode = opc_tab[idx];
        bus.funct  = (opc_tab[idx] == 6'h00 || opc_tab[idx] == 6'h1c) ? fn_tab[idx] : 6'($urandom);
        bus.shamt  = 5'($urandom);
        bus.imm    = 16'($urandom);
        bus.rs_val = $urandom;
        bus.rt_val = ($urandom_range(0, 3) == 0) ? bus.rs_val : $urandom;
    endtask

    task automatic issue(input logic [5:0] opc, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [15:0] im, input logic [31:0] rs, input logic [31:0] rt);
        bit acc;
        int n;
        bus.opcode = opc; bus.funct = fn; bus.shamt = sh;
        bus.imm = im; bus.rs_val = rs; bus.rt_val = rt;
        bus.in_valid = 1'b1;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 20) begin
            tick(acc);
            n++;
        end
        bus.in_valid = 1'b0;
        chk("accept", 32'(acc), 32'd1);
    endtask

    task automatic drain(input string tag);
        bit acc;
        int n;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 20) begin
            tick(acc);
            n++;
        end
        chk(tag, q.size(), 32'd0);
    endtask

    initial begin
        bit acc;
        int k;
        int cyc;
        int n0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.opcode = 6'd0; bus.funct = 6'd0; bus.shamt = 5'd0;
        bus.imm = 16'd0; bus.rs_val = 32'd0; bus.rt_val = 32'd0;

        // Reset state
        rst = 1'b1;
        tick(acc);
        tick(acc);
        rst = 1'b0;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("rst_alu_a", bus.alu_a, 32'd0);
        chk("rst_alu_b", bus.alu_b, 32'd0);
        chk("rst_out_result", bus.out_result, 32'd0);
        chk("rst_out_zero", 32'(bus.out_zero), 32'd0);
        chk("rst_out_illegal", 32'(bus.out_illegal), 32'd0);

        // addi rs=5 imm=-1
        issue(6'h08, 6'h00, 5'd0, 16'hFFFF, 32'd5, 32'd0);
        chk("addi_op", 32'(bus.alu_op), 32'd0);
        chk("addi_a", bus.alu_a, 32'd5);
        chk("addi_b", bus.alu_b, 32'hFFFF_FFFF);
        tick(acc);
        chk("addi_valid", 32'(bus.out_valid), 32'd1);
        chk("addi_result", bus.out_result, 32'd4);
        chk("addi_zero", 32'(bus.out_zero), 32'd0);

        // beq equal, bne unequal
        issue(6'h04, 6'h00, 5'd0, 16'h0010, 32'h1234, 32'h1234);
        chk("beq_op", 32'(bus.alu_op), 32'd1);
        tick(acc);
        chk("beq_zero", 32'(bus.out_zero), 32'd1);
        issue(6'h05, 6'h00, 5'd0, 16'h0010, 32'd1, 32'd2);
        chk("bne_op", 32'(bus.alu_op), 32'd1);
        tick(acc);
        chk("bne_zero", 32'(bus.out_zero), 32'd0);

        // sra by shamt, srlv by rs[4:0]
        issue(6'h00, 6'h03, 5'd4, 16'd0, 32'h55, 32'h8000_0000);
        chk("sra_op", 32'(bus.alu_op), 32'd11);
        chk("sra_a", bus.alu_a, 32'h8000_0000);
        chk("sra_b", bus.alu_b, 32'd4);
        tick(acc);
        chk("sra_result", bus.out_result, 32'hF800_0000);
        issue(6'h00, 6'h06, 5'd9, 16'd0, 32'h23, 32'hF0);
        chk("srlv_op", 32'(bus.alu_op), 32'd10);
        chk("srlv_a", bus.alu_a, 32'hF0);
        chk("srlv_b", bus.alu_b, 32'd3);

        // nor is unsupported
        issue(6'h00, 6'h27, 5'd0, 16'd0, 32'hDEAD, 32'hBEEF);
        chk("nor_op", 32'(bus.alu_op), 32'd0);
        chk("nor_a", bus.alu_a, 32'd0);
        chk("nor_b", bus.alu_b, 32'd0);
        tick(acc);
        chk("nor_illegal", 32'(bus.out_illegal), 32'd1);
        chk("nor_result", bus.out_result, 32'd0);
        chk("nor_zero", 32'(bus.out_zero), 32'd0);

        // mul depends on build option
        issue(6'h1c, 6'h02, 5'd0, 16'd0, 32'd7, 32'd6);
`ifdef ALU_ISSUE_MUL_EN
        chk("mul_op", 32'(bus.alu_op), 32'd2);
        tick(acc);
        chk("mul_result", bus.out_result, 32'd42);
        chk("mul_illegal", 32'(bus.out_illegal), 32'd0);
`else
        chk("mul_op_off", 32'(bus.alu_op), 32'd0);
        tick(acc);
        chk("mul_illegal_off", 32'(bus.out_illegal), 32'd1);
`endif
        drain("drain_directed");

        // Full throughput with out_ready held high
        k = 0; cyc = 0;
        bus.out_ready = 1'b1;
        set_rand();
        bus.in_valid = 1'b1;
        while (k < 8 && cyc < 100) begin
            tick(acc);
            cyc++;
            if (acc) begin k++; set_rand(); end
        end
        chk("throughput_cycles", cyc, 32'd8);
        drain("drain_throughput");

        // Eight back-to-back with out_ready 1,0,0,1,...
        n0 = n_out; k = 0; cyc = 0;
        set_rand();
        bus.in_valid = 1'b1;
        while (k < 8 && cyc < 200) begin
            bus.out_ready = rdy_pat[cyc[1:0]];
            tick(acc);
            cyc++;
            if (acc) begin k++; set_rand(); end
        end
        bus.in_valid = 1'b0;
        while (q.size() > 0 && cyc < 200) begin
            bus.out_ready = rdy_pat[cyc[1:0]];
            tick(acc);
            cyc++;
        end
        chk("b2b_accepted", k, 32'd8);
        chk("b2b_delivered", n_out - n0, 32'd8);
        drain("drain_b2b");

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            set_rand();
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick(acc);
        end
        drain("drain_random");

        // Reset with both stages full
        bus.out_ready = 1'b0;
        set_rand();
        issue(bus.opcode, bus.funct, bus.shamt, bus.imm, bus.rs_val, bus.rt_val);
        set_rand();
        issue(bus.opcode, bus.funct, bus.shamt, bus.imm, bus.rs_val, bus.rt_val);
        chk("full_out_valid", 32'(bus.out_valid), 32'd1);
        chk("full_in_ready", 32'(bus.in_ready), 32'd0);
        n0 = n_out;
        rst = 1'b1;
        set_rand();
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        tick(acc);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("midrst_out_result", bus.out_result, 32'd0);
        chk("midrst_alu_op", 32'(bus.alu_op), 32'd0);
        chk("midrst_alu_a", bus.alu_a, 32'd0);
        for (int i = 0; i < 4; i++) tick(acc);
        chk("midrst_no_stale", n_out - n0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
